mmio_host_rx: RTL and testbench

//  AHB3-Lite slave on the data bus. It is the host->target counterpart of the testbench MMIO write catcher.
//  It serves core reads of a simulated UART receive FIFO, a status register and a FROMHOST mailbox.
//  The bench pushes bytes and mailbox words from its side; the core consumes them with loads.

---
 rtl/mmio_host_rx.sv | 212 +++++++++++++++++++++
 tb/tb_mmio_host_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_host_rx.sv
// AHB3-Lite slave serving a bench-fed UART RX FIFO, a STATUS register and a FROMHOST mailbox.
// Optional feature macro MMIO_HOST_RX_IRQ_EN: adds STATUS[18] irq_en and the rx_irq output.
module mmio_host_rx #(
  parameter int                    HDATA_SIZE  = 32,
  parameter int                    HADDR_SIZE  = 32,
  parameter logic [HADDR_SIZE-1:0] UART_RX     = 'h8000_1084,
  parameter logic [HADDR_SIZE-1:0] UART_STAT   = 'h8000_1088,
  parameter logic [HADDR_SIZE-1:0] FROMHOST    = 'h8000_1040,
  parameter int                    FIFO_DEPTH  = 16,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  input  logic                  rx_push,
  input  logic [7:0]            rx_data,
  output logic                  rx_full,
  input  logic                  fromhost_we,
`ifdef MMIO_HOST_RX_IRQ_EN
  output logic                  rx_irq,
`endif
  input  logic [HDATA_SIZE-1:0] fromhost_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              wcnt_q, wcnt_d;
  logic [HADDR_SIZE-1:0]   haddr_q, haddr_d;
  logic                    hwrite_q, hwrite_d;
  logic [HDATA_SIZE-1:0]   hrdata_q, hrdata_d;
  logic                    hready_q, hready_d;
  logic                    hresp_q, hresp_d;
  logic [7:0]              mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    full_q, full_d;
  logic                    ovr_q, ovr_d;
  logic                    irq_en_q, irq_en_d;
  logic [HDATA_SIZE-1:0]   mbox_q, mbox_d;

  logic                    accept, done, pop, push_ok, ld_rdata, mapped, lw;
  logic [HADDR_SIZE-1:0]   la;
  logic [7:0]              head;
  logic [HDATA_SIZE-1:0]   rd;

  logic unused_bits;
  assign unused_bits = ^{HSIZE, HBURST, HTRANS[0], HWDATA};

  always_comb begin
    accept  = HSEL & HREADY & HTRANS[1];
    done    = (state_q == S_DONE);
    pop     = done & ~hwrite_q & (haddr_q == UART_RX) & (count_q != '0);
    // A push into a full FIFO still lands when the same cycle pops.
    push_ok = rx_push & (~full_q | pop);

    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    full_d   = (count_d == CW'(FIFO_DEPTH));

    ovr_d    = ovr_q;
    irq_en_d = irq_en_q;
    if (done & hwrite_q & (haddr_q == UART_STAT)) begin
      if (HWDATA[17]) ovr_d = 1'b0;
`ifdef MMIO_HOST_RX_IRQ_EN
      irq_en_d = HWDATA[18];
`endif
    end
    if (rx_push & full_q & ~pop) ovr_d = 1'b1;

    mbox_d = mbox_q;
    if (done & hwrite_q & (haddr_q == FROMHOST)) mbox_d = '0;
    if (fromhost_we) mbox_d = fromhost_data;

    // Read data is built from post-edge state so pipelined reads see this cycle's pop/push.
    la     = (state_q == S_WAIT) ? haddr_q : HADDR;
    lw     = (state_q == S_WAIT) ? hwrite_q : HWRITE;
    mapped = (la == UART_RX) | (la == UART_STAT) | (la == FROMHOST);
    head   = (push_ok && wr_ptr_q == rd_ptr_d) ? rx_data : mem_q[rd_ptr_d];
    rd     = '0;
    if (la == UART_RX) begin
      if (count_d == '0) rd[31] = 1'b1;
      else               rd[7:0] = head;
    end else if (la == UART_STAT) begin
      rd[CW-1:0] = count_d;
      rd[16]     = full_d;
      rd[17]     = ovr_d;
      rd[18]     = irq_en_d;
    end else if (la == FROMHOST) begin
      rd = mbox_d;
    end

    state_d  = state_q;
    wcnt_d   = wcnt_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hrdata_d = hrdata_q;
    hready_d = hready_q;
    hresp_d  = hresp_q;
    ld_rdata = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (wcnt_q == '0) begin
          state_d  = S_DONE;
          hready_d = 1'b1;
          ld_rdata = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      S_ERR1: begin
        state_d  = S_ERR2;
        hready_d = 1'b1;
        hresp_d  = 1'b1;
      end
      default: begin
        if (accept) begin
          haddr_d  = HADDR;
          hwrite_d = HWRITE;
          if (!mapped) begin
            state_d  = S_ERR1;
            hready_d = 1'b0;
            hresp_d  = 1'b1;
            hrdata_d = '0;
          end else if (WAIT_STATES > 0) begin
            state_d  = S_WAIT;
            wcnt_d   = 3'(WAIT_STATES - 1);
            hready_d = 1'b0;
            hresp_d  = 1'b0;
          end else begin
            state_d  = S_DONE;
            hready_d = 1'b1;
            hresp_d  = 1'b0;
            ld_rdata = 1'b1;
          end
        end else begin
          state_d  = S_IDLE;
          hready_d = 1'b1;
          hresp_d  = 1'b0;
        end
      end
    endcase
    if (ld_rdata) hrdata_d = lw ? '0 : rd;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hrdata_q <= '0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovr_q    <= 1'b0;
      irq_en_q <= 1'b0;
      mbox_q   <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hrdata_q <= hrdata_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovr_q    <= ovr_d;
      irq_en_q <= irq_en_d;
      mbox_q   <= mbox_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_data;
  end

`ifdef MMIO_HOST_RX_IRQ_EN
  logic rx_irq_q;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) rx_irq_q <= 1'b0;
    else          rx_irq_q <= irq_en_q & (count_q != '0);
  end
  assign rx_irq = rx_irq_q;
`endif

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;
  assign rx_full   = full_q;

endmodule

// File: tb/tb_mmio_host_rx.sv
// Bench for mmio_host_rx: directed scenarios plus random traffic against a queue-based model.
module tb_mmio_host_rx;
  localparam int DEPTH = 16;
  localparam int WS    = 3;
  localparam logic [31:0] A_RX = 32'h8000_1084, A_ST = 32'h8000_1088;
  localparam logic [31:0] A_FH = 32'h8000_1040, A_BAD = 32'h8000_1090;

  logic        HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'd2, HBURST = 3'd0;
  logic [31:0] HADDR = '0, HWDATA = '0, HRDATA, fromhost_data = '0;
  logic        HREADY, HREADYOUT, HRESP, rx_full, rx_push = 1'b0, fromhost_we = 1'b0;
  logic [7:0]  rx_data = '0;
`ifdef MMIO_HOST_RX_IRQ_EN
  logic        rx_irq;
`endif

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  mmio_host_rx #(.FIFO_DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
    .HRESETn(HRESETn), .HCLK(HCLK), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .rx_push(rx_push), .rx_data(rx_data), .rx_full(rx_full),
    .fromhost_we(fromhost_we),
`ifdef MMIO_HOST_RX_IRQ_EN
    .rx_irq(rx_irq),
`endif
    .fromhost_data(fromhost_data)
  );

  int tests = 0, fails = 0;

  // Reference model: bytes waiting, sticky overrun, irq enable, mailbox.
  byte unsigned q[$];
  bit           ovr = 1'b0, irq_en = 1'b0;
  logic [31:0]  mbox = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = '0;
    s[15:0]  = 16'(q.size());
    s[16]    = (q.size() == DEPTH);
    s[17]    = ovr;
`ifdef MMIO_HOST_RX_IRQ_EN
    s[18]    = irq_en;
`endif
    return s;
  endfunction

  task automatic push(input logic [7:0] b);
    @(negedge HCLK); rx_push = 1'b1; rx_data = b;
    @(posedge HCLK); #1 rx_push = 1'b0;
    if (q.size() < DEPTH) q.push_back(b); else ovr = 1'b1;
  endtask

  task automatic fh_load(input logic [31:0] v);
    @(negedge HCLK); fromhost_we = 1'b1; fromhost_data = v;
    @(posedge HCLK); #1 fromhost_we = 1'b0;
    mbox = v;
  endtask

  // One AHB transfer; side=1 pushes sv[7:0], side=2 loads mailbox sv, both in the final data cycle.
  task automatic access(input string tag, input logic [31:0] a, input bit wr, input logic [31:0] wd,
                        input int side, input logic [31:0] sv, output logic [31:0] rdat);
    int low;
    logic r0, r1;
    bit mapped;
    logic [31:0] exp;
    mapped = (a == A_RX) || (a == A_ST) || (a == A_FH);
    @(negedge HCLK); HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = wr;
    @(posedge HCLK);
    @(negedge HCLK); HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
    r0 = HRESP; low = 0;
    while (HREADYOUT !== 1'b1 && low < 20) begin low++; @(negedge HCLK); end
    rdat = HRDATA; r1 = HRESP;
    exp = '0;
    if (!mapped) begin
      chk({tag, "_errlow"}, 32'(low), 32'd1);
      chk({tag, "_resp1"}, {31'b0, r0}, 32'd1);
      chk({tag, "_resp2"}, {31'b0, r1}, 32'd1);
    end else begin
      chk({tag, "_waits"}, 32'(low), 32'(WS));
      chk({tag, "_resp"}, {30'b0, r0, r1}, 32'd0);
      if (!wr) begin
        if (a == A_RX)      exp = (q.size() == 0) ? 32'h8000_0000 : {24'h0, q[0]};
        else if (a == A_ST) exp = exp_status();
        else                exp = mbox;
        chk({tag, "_data"}, rdat, exp);
      end
    end
    if (side == 1) begin rx_push = 1'b1; rx_data = sv[7:0]; end
    if (side == 2) begin fromhost_we = 1'b1; fromhost_data = sv; end
    @(posedge HCLK); #1 rx_push = 1'b0; fromhost_we = 1'b0;
    if (mapped) begin
      if (!wr && a == A_RX && q.size() != 0) void'(q.pop_front());
      if (wr && a == A_ST) begin
        if (wd[17]) ovr = 1'b0;
`ifdef MMIO_HOST_RX_IRQ_EN
        irq_en = wd[18];
`endif
      end
      if (wr && a == A_FH) mbox = '0;
    end
    if (side == 1) begin
      if (q.size() < DEPTH) q.push_back(sv[7:0]); else ovr = 1'b1;
    end
    if (side == 2) mbox = sv;
    chk({tag, "_full"}, {31'b0, rx_full}, {31'b0, q.size() == DEPTH});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int low;
    int r;

    // Reset state
    #12;
    chk("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    chk("rst_hresp", {31'b0, HRESP}, 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_full", {31'b0, rx_full}, 32'd0);
    @(negedge HCLK); HRESETn = 1'b1;
    access("t1_stat", A_ST, 1'b0, 0, 0, 0, d);
    chk("t1_stat_zero", d, 32'h0);

    // Two bytes in, three reads out
    push(8'h41); push(8'h42);
    access("t2_st2", A_ST, 1'b0, 0, 0, 0, d);  chk("t2_cnt2", d, 32'h2);
    access("t2_rx1", A_RX, 1'b0, 0, 0, 0, d);  chk("t2_41", d, 32'h41);
    access("t2_rx2", A_RX, 1'b0, 0, 0, 0, d);  chk("t2_42", d, 32'h42);
    access("t2_rx3", A_RX, 1'b0, 0, 0, 0, d);  chk("t2_empty", d, 32'h8000_0000);
    access("t2_st0", A_ST, 1'b0, 0, 0, 0, d);  chk("t2_cnt0", d, 32'h0);
    access("t2_rxwr", A_RX, 1'b1, 32'h55, 0, 0, d);

    // Back-to-back NONSEQ: second address held through the first data phase's waits
    fh_load(32'h1234_5678);
    @(negedge HCLK); HSEL = 1'b1; HTRANS = 2'b10; HADDR = A_ST; HWRITE = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK); HADDR = A_FH;
    low = 0;
    while (HREADYOUT !== 1'b1 && low < 20) begin low++; @(negedge HCLK); end
    chk("t3_low1", 32'(low), 32'(WS));
    chk("t3_d1", HRDATA, exp_status());
    @(posedge HCLK);
    @(negedge HCLK); HSEL = 1'b0; HTRANS = 2'b00;
    low = 0;
    while (HREADYOUT !== 1'b1 && low < 20) begin low++; @(negedge HCLK); end
    chk("t3_low2", 32'(low), 32'(WS));
    chk("t3_d2", HRDATA, 32'h1234_5678);
    @(posedge HCLK); #1;

    // Overfill, clear overrun, push+pop while full
    for (int i = 0; i < 17; i++) push(8'(8'h60 + i));
    chk("t4_full", {31'b0, rx_full}, 32'd1);
    access("t4_st", A_ST, 1'b0, 0, 0, 0, d);   chk("t4_st_ovr", d, 32'h0003_0010);
    access("t4_clr", A_ST, 1'b1, 32'h0002_0000, 0, 0, d);
    access("t4_st2", A_ST, 1'b0, 0, 0, 0, d);  chk("t4_st_clr", d, 32'h0001_0010);
    access("t4_pp", A_RX, 1'b0, 0, 1, 32'hA5, d); chk("t4_pp_head", d, 32'h60);
    access("t4_st3", A_ST, 1'b0, 0, 0, 0, d);  chk("t4_st_pp", d, 32'h0001_0010);
    for (int i = 0; i < DEPTH; i++) access("t4_drain", A_RX, 1'b0, 0, 0, 0, d);
    chk("t4_last", d, 32'hA5);

    // Mailbox: bench load beats a same-cycle core clear
    fh_load(32'h0000_0001);
    access("t5_wr", A_FH, 1'b1, 32'hFFFF_FFFF, 2, 32'hDEAD, d);
    access("t5_rd", A_FH, 1'b0, 0, 0, 0, d);   chk("t5_dead", d, 32'hDEAD);
    access("t5_clr", A_FH, 1'b1, 32'h7, 0, 0, d);
    access("t5_rd0", A_FH, 1'b0, 0, 0, 0, d);  chk("t5_zero", d, 32'h0);

    // Unmapped address
    access("t6_bad_rd", A_BAD, 1'b0, 0, 0, 0, d);
    access("t6_bad_wr", A_BAD, 1'b1, 32'h1, 0, 0, d);
`ifdef MMIO_HOST_RX_IRQ_EN
    access("t6_irqen", A_ST, 1'b1, 32'h0004_0000, 0, 0, d);
    push(8'h77);
    repeat (2) @(negedge HCLK);
    chk("t6_irq_hi", {31'b0, rx_irq}, 32'd1);
    access("t6_pop", A_RX, 1'b0, 0, 0, 0, d);
    repeat (2) @(negedge HCLK);
    chk("t6_irq_lo", {31'b0, rx_irq}, 32'd0);
    access("t6_irqdis", A_ST, 1'b1, 32'h0, 0, 0, d);
`endif

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: begin
          int n;
          n = $urandom_range(1, 6);
          for (int k = 0; k < n; k++) push(8'($urandom));
        end
        3: access("rnd_rx", A_RX, 1'b0, 0, 0, 0, d);
        4: access("rnd_st", A_ST, 1'b0, 0, 0, 0, d);
        5: access("rnd_stwr", A_ST, 1'b1, $urandom, 0, 0, d);
        6: fh_load($urandom);
        7: access("rnd_fh", A_FH, $urandom_range(0, 1) == 1, $urandom, 0, 0, d);
        8: access("rnd_rxpush", A_RX, 1'b0, 0, 1, $urandom, d);
        default: begin
          if ($urandom_range(0, 1) == 1) access("rnd_bad", A_BAD, $urandom_range(0, 1) == 1, 0, 0, 0, d);
          else access("rnd_fhwe", A_FH, 1'b1, $urandom, 2, $urandom, d);
        end
      endcase
    end
    access("rnd_final_st", A_ST, 1'b0, 0, 0, 0, d);

    // Reset in the middle of a waited transfer
    push(8'h11);
    @(negedge HCLK); HSEL = 1'b1; HTRANS = 2'b10; HADDR = A_ST; HWRITE = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK); HSEL = 1'b0; HTRANS = 2'b00;
    chk("mid_waiting", {31'b0, HREADYOUT}, 32'd0);
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, HREADYOUT}, 32'd1);
    chk("mid_rst_resp", {31'b0, HRESP}, 32'd0);
    q.delete(); ovr = 1'b0; irq_en = 1'b0; mbox = '0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    access("mid_st", A_ST, 1'b0, 0, 0, 0, d);  chk("mid_st_zero", d, 32'h0);
    access("mid_rx", A_RX, 1'b0, 0, 0, 0, d);  chk("mid_rx_empty", d, 32'h8000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
